// File: rtl/kpscan_ctrl.sv
// ----------------------------------------------------------------------------
// kpscan_ctrl
// Keypad scan controller for the 4x4 game keypad.
//
// Walks a single low strobe across the four column lines, synchronises the
// raw row lines, debounces both press and release, and queues one
// {column, row} event per debounced single-key press. The keypad decoder and
// game logic consume the events through a valid/ready handshake.
//
// Parameters
//   SCAN_DIV   : cycles each column is driven before rows are sampled (>= 3)
//   DEBOUNCE   : consecutive stable cycles to accept a press or release (>= 1)
//   FIFO_DEPTH : event queue depth, power of two, >= 2
//
// Ports
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   kpr_in     : raw row lines, active low, asynchronous to clk
//   kpc        : column drive, one-hot-low (0111, 1011, 1101, 1110)
//   key_kpc    : column pattern of the head event, 4'hF when empty
//   key_kpr    : row pattern of the head event, 4'hF when empty
//   key_valid  : event queue non-empty
//   key_ready  : consumer accepts the head event (pop on valid && ready)
//   key_held   : a debounced key is currently down
//   overflow   : sticky, an event was dropped because the queue was full
//   fifo_count : number of queued events
// ----------------------------------------------------------------------------
module kpscan_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 1000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    kpr_in,
  output logic [3:0]                    kpc,
  output logic [3:0]                    key_kpc,
  output logic [3:0]                    key_kpr,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          key_held,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // One counter serves both the column dwell and the debounce windows.
  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_FW  = PTR_W + 1;

  localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_FW-1:0] FIFO_FULL = CNT_FW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  // Column index to one-hot-low strobe.
  function automatic logic [3:0] col_to_kpc(input logic [1:0] c);
    logic [3:0] pat;
    case (c)
      2'd0:    pat = 4'b0111;
      2'd1:    pat = 4'b1011;
      2'd2:    pat = 4'b1101;
      default: pat = 4'b1110;
    endcase
    return pat;
  endfunction

  // True when exactly one row line is pulled low (a single key).
  function automatic logic single_key(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        kpr_s_q, kpr_s_d;

  state_e            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        kpc_q, kpc_d;
  logic              held_q, held_d;

  // Event handed from the scanner to the queue one cycle after acceptance.
  logic              push_q, push_d;
  logic [7:0]        push_data_q, push_data_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [7:0]        head_q, head_d;
  logic              ovf_q, ovf_d;

  logic              pop;
  logic              full;
  logic              do_write;
  logic              drop;

  // --------------------------------------------------------------------------
  // Row synchroniser and scan / debounce state machine (next-state logic)
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave a latch behind.
    sync1_d     = kpr_in;
    kpr_s_d     = sync1_q;
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    unique case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (kpr_s_q != 4'hF) begin
            cand_d  = kpr_s_q;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (kpr_s_q != cand_q) begin
          // Bounce: abandon this column without an event.
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          // Multi-key patterns still walk through PRESSED/RELEASE so the
          // scanner waits for the keys to come up, but are never queued.
          state_d     = ST_PRESSED;
          cnt_d       = '0;
          push_d      = single_key(cand_q);
          push_data_d = {kpc_q, cand_q};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PRESSED: begin
        if (kpr_s_q == 4'hF) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (kpr_s_q != 4'hF) begin
          // Release bounce: key is still down, no new event.
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase

    // Strobe and held flag are registered from the next state so they change
    // on the same edge as the state itself, glitch-free at the pins.
    kpc_d  = col_to_kpc(col_d);
    held_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
  end

  // --------------------------------------------------------------------------
  // Event queue (next-state logic)
  // --------------------------------------------------------------------------
  always_comb begin
    pop      = (count_q != '0) && key_ready;
    full     = (count_q == FIFO_FULL);
    // A full queue can still accept a push when the head leaves this cycle.
    do_write = push_q && (!full || pop);
    drop     = push_q && full && !pop;

    wr_ptr_d = do_write ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (do_write && !pop) begin
      count_d = count_q + CNT_FW'(1);
    end else if (!do_write && pop) begin
      count_d = count_q - CNT_FW'(1);
    end

    ovf_d = ovf_q | drop;

    // Head register shows what storage will hold at rd_ptr_d after this edge,
    // forwarding the incoming event when it lands in that very slot.
    if (count_d == '0) begin
      head_d = 8'hFF;
    end else if (do_write && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data_q;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 4'hF;
      kpr_s_q     <= 4'hF;
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      cnt_q       <= '0;
      cand_q      <= 4'hF;
      kpc_q       <= 4'b0111;
      held_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= 8'hFF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= 8'hFF;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      kpr_s_q     <= kpr_s_d;
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      kpc_q       <= kpc_d;
      held_q      <= held_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; an entry is only ever read
  // after it has been written, and the count/pointers carry the reset state.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign kpc        = kpc_q;
  assign key_kpc    = head_q[7:4];
  assign key_kpr    = head_q[3:0];
  assign key_valid  = (count_q != '0);
  assign key_held   = held_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule
